// File: rtl/shift_regs_pkg.sv
// Shared definitions for the shift-register datapath sequencer.
// Contents: FSM state encoding, datapath geometry constants, legal
// k/s/pad values and a window-fit helper used by the top-level check.
package shift_regs_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_MIN   = 3'd3,
      ST_SHIFT = 3'd4
   } state_e;

   localparam logic [15:0] SHIFT_REGS_NUM   = 16'd70;
   localparam logic [15:0] PIXELS_IN_ROW    = 16'd32;
   localparam logic [1:0]  CHUNKS_PER_STRIP = 2'd2;

   localparam logic [3:0] K_1   = 4'd1;
   localparam logic [3:0] K_3   = 4'd3;
   localparam logic [3:0] S_1   = 4'd1;
   localparam logic [3:0] S_2   = 4'd2;
   localparam logic [3:0] PAD_0 = 4'd0;
   localparam logic [3:0] PAD_1 = 4'd1;

   // True when a load window ending at reg_end plus the east padding
   // still lands inside the datapath register file.
   function automatic logic window_fits(input logic [15:0] reg_end,
                                        input logic [3:0]  east_pad);
      return (reg_end + {12'd0, east_pad}) <= SHIFT_REGS_NUM;
   endfunction

endpackage

// File: rtl/shift_regs_win_calc.sv
// Combinational load-window calculator for one chunk fetch.
// Inputs : col_i (first column of chunk), chunk_i (index within strip),
//          slab_i (registers already holding overlap from the prior strip),
//          pad_i, in_w_i (tile config), prev_end_i (reg_end of chunk 0).
// Outputs: n_o (pixels in chunk), row_end_o (last column), west_pad_o,
//          reg_start_o / reg_end_o (1-based datapath load window).
module shift_regs_win_calc
   import shift_regs_pkg::*;
(
   input  logic [15:0] col_i,
   input  logic [1:0]  chunk_i,
   input  logic [3:0]  slab_i,
   input  logic [3:0]  pad_i,
   input  logic [15:0] in_w_i,
   input  logic [15:0] prev_end_i,
   output logic [15:0] n_o,
   output logic [15:0] row_end_o,
   output logic [3:0]  west_pad_o,
   output logic [15:0] reg_start_o,
   output logic [15:0] reg_end_o
);

   logic [15:0] remain;

   always_comb begin
      remain     = in_w_i - col_i;
      n_o        = (remain > PIXELS_IN_ROW) ? PIXELS_IN_ROW : remain;
      row_end_o  = col_i + n_o - 16'd1;
      // West padding only precedes the very first pixel of an output row.
      west_pad_o = (col_i == 16'd0 && chunk_i == 2'd0) ? pad_i : 4'd0;
      // The second chunk packs directly behind the first one.
      if (chunk_i == 2'd0)
         reg_start_o = {12'd0, slab_i} + {12'd0, west_pad_o} + 16'd1;
      else
         reg_start_o = prev_end_i + 16'd1;
      reg_end_o  = reg_start_o + n_o - 16'd1;
   end

endmodule

// File: rtl/shift_regs_ctrl.sv
// Sequencer for the 70-entry, 3-row shift-register datapath.
// Walks a tile row by row and strip by strip, requesting up to two 32-pixel
// chunks per strip, drives the datapath load window and pads, issues the
// min-pixels / all-pixels end pulses and waits for the datapath shift-done.
// Ports: clk, reset (async active-low), start/k/s/pad/in_w/in_h (tile config),
//        rd_req/rd_ack + row_start/end_idx (row buffer), row1..3_idx and
//        row_valid (input rows of the current output row), west_pad/slab_num/
//        east_pad/reg_start/end_idx (datapath fill), conv_*_add_end pulses,
//        shift_add_end (datapath shift complete), busy, done.
module shift_regs_ctrl
   import shift_regs_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [3:0]         k,
   input  logic [3:0]         s,
   input  logic [3:0]         pad,
   input  logic [15:0]        in_w,
   input  logic [15:0]        in_h,
   output logic               rd_req,
   input  logic               rd_ack,
   output logic [15:0]        row_start_idx,
   output logic [15:0]        row_end_idx,
   output logic signed [15:0] row1_idx,
   output logic signed [15:0] row2_idx,
   output logic signed [15:0] row3_idx,
   output logic [2:0]         row_valid,
   output logic [3:0]         west_pad,
   output logic [3:0]         slab_num,
   output logic [3:0]         east_pad,
   output logic [15:0]        reg_start_idx,
   output logic [15:0]        reg_end_idx,
   output logic               conv_min_pixels_add_end,
   output logic               conv_pixels_add_end,
   input  logic               shift_add_end,
   output logic               busy,
   output logic               done
);

   state_e      state_q, state_d;
   logic [3:0]  k_q, k_d, s_q, s_d, pad_q, pad_d;
   logic [15:0] in_w_q, in_w_d, in_h_q, in_h_d;
   logic [15:0] oy_q, oy_d, col_q, col_d, prev_end_q, prev_end_d;
   logic [1:0]  chunk_q, chunk_d;
   logic [3:0]  slab_q, slab_d, east_q, east_d;
   logic        pix_end_q, pix_end_d, done_q, done_d;

   logic [15:0] win_n, win_row_end, win_reg_start, win_reg_end;
   logic [3:0]  win_west;
   logic [19:0] next_span, row_limit;
   logic        last_row, fetch, active;
   logic signed [15:0] row_base;

   shift_regs_win_calc u_win (
      .col_i       (col_q),
      .chunk_i     (chunk_q),
      .slab_i      (slab_q),
      .pad_i       (pad_q),
      .in_w_i      (in_w_q),
      .prev_end_i  (prev_end_q),
      .n_o         (win_n),
      .row_end_o   (win_row_end),
      .west_pad_o  (win_west),
      .reg_start_o (win_reg_start),
      .reg_end_o   (win_reg_end)
   );

   // The next output row exists while its last kernel row stays inside the
   // padded input: (oy+1)*s + k - 1 <= in_h + 2*pad - 1.
   assign next_span = (20'(oy_q) + 20'd1) * 20'(s_q) + 20'(k_q);
   assign row_limit = 20'(in_h_q) + 20'(pad_q) + 20'(pad_q);
   assign last_row  = next_span > row_limit;

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      s_d        = s_q;
      pad_d      = pad_q;
      in_w_d     = in_w_q;
      in_h_d     = in_h_q;
      oy_d       = oy_q;
      col_d      = col_q;
      prev_end_d = prev_end_q;
      chunk_d    = chunk_q;
      slab_d     = slab_q;
      east_d     = east_q;
      pix_end_d  = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // Out-of-range config is coerced to the nearest legal value.
               k_d     = (k == K_3)     ? K_3   : K_1;
               s_d     = (s == S_2)     ? S_2   : S_1;
               pad_d   = (pad == PAD_1) ? PAD_1 : PAD_0;
               in_w_d  = in_w;
               in_h_d  = in_h;
               oy_d    = 16'd0;
               col_d   = 16'd0;
               chunk_d = 2'd0;
               slab_d  = 4'd0;
               east_d  = 4'd0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (rd_ack) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            col_d      = col_q + win_n;
            chunk_d    = chunk_q + 2'd1;
            prev_end_d = win_reg_end;
            if ((chunk_q + 2'd1) < CHUNKS_PER_STRIP && (col_q + win_n) < in_w_q)
               state_d = ST_FETCH;
            else
               state_d = ST_MIN;
         end
         ST_MIN: begin
            if (col_q == in_w_q) begin
               east_d    = pad_q;
               pix_end_d = 1'b1;
            end
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (shift_add_end) begin
               // k-1 columns of the previous strip stay in the datapath.
               slab_d  = k_q - 4'd1;
               chunk_d = 2'd0;
               if (col_q < in_w_q) begin
                  state_d = ST_FETCH;
               end else begin
                  oy_d   = oy_q + 16'd1;
                  col_d  = 16'd0;
                  slab_d = 4'd0;
                  east_d = 4'd0;
                  if (last_row) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_FETCH;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         k_q        <= '0;
         s_q        <= '0;
         pad_q      <= '0;
         in_w_q     <= '0;
         in_h_q     <= '0;
         oy_q       <= '0;
         col_q      <= '0;
         prev_end_q <= '0;
         chunk_q    <= '0;
         slab_q     <= '0;
         east_q     <= '0;
         pix_end_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         s_q        <= s_d;
         pad_q      <= pad_d;
         in_w_q     <= in_w_d;
         in_h_q     <= in_h_d;
         oy_q       <= oy_d;
         col_q      <= col_d;
         prev_end_q <= prev_end_d;
         chunk_q    <= chunk_d;
         slab_q     <= slab_d;
         east_q     <= east_d;
         pix_end_q  <= pix_end_d;
         done_q     <= done_d;
      end
   end

   // Outputs: the fetch window is only meaningful while a request is open,
   // and row indices only while a tile is in progress, so both read 0 idle.
   assign fetch    = (state_q == ST_FETCH);
   assign active   = (state_q != ST_IDLE);
   assign row_base = signed'(oy_q * {12'd0, s_q}) - signed'({12'd0, pad_q});

   always_comb begin
      rd_req                  = fetch;
      row_start_idx           = fetch ? col_q         : 16'd0;
      row_end_idx             = fetch ? win_row_end   : 16'd0;
      reg_start_idx           = fetch ? win_reg_start : 16'd0;
      reg_end_idx             = fetch ? win_reg_end   : 16'd0;
      west_pad                = fetch ? win_west      : 4'd0;
      row1_idx                = active ? row_base           : 16'sd0;
      row2_idx                = active ? row_base + 16'sd1  : 16'sd0;
      row3_idx                = active ? row_base + 16'sd2  : 16'sd0;
      row_valid[0]            = active && !row1_idx[15] && ($unsigned(row1_idx) < in_h_q);
      row_valid[1]            = active && !row2_idx[15] && ($unsigned(row2_idx) < in_h_q);
      row_valid[2]            = active && !row3_idx[15] && ($unsigned(row3_idx) < in_h_q);
      slab_num                = slab_q;
      east_pad                = east_q;
      conv_min_pixels_add_end = (state_q == ST_MIN);
      conv_pixels_add_end     = pix_end_q;
      busy                    = active;
      done                    = done_q;
   end

   a_window_fits: assert property (@(posedge clk) disable iff (!reset)
      fetch |-> window_fits(win_reg_end, pad_q));

endmodule

// File: tb/tb_shift_regs_ctrl.sv
module tb_shift_regs_ctrl;

   localparam int EV_NONE  = 0;
   localparam int EV_FETCH = 1;
   localparam int EV_MIN   = 2;
   localparam int EV_PIX   = 3;
   localparam int EV_DONE  = 4;

   typedef struct {
      int         kind;
      int         rs;
      int         re;
      int         gs;
      int         ge;
      int         wp;
      int         slab;
      int         r1;
      logic [2:0] rv;
   } ev_t;

   logic               clk, reset, start;
   logic [3:0]         k, s, pad;
   logic [15:0]        in_w, in_h;
   logic               rd_req, rd_ack;
   logic [15:0]        row_start_idx, row_end_idx;
   logic signed [15:0] row1_idx, row2_idx, row3_idx;
   logic [2:0]         row_valid;
   logic [3:0]         west_pad, slab_num, east_pad;
   logic [15:0]        reg_start_idx, reg_end_idx;
   logic               conv_min_pixels_add_end, conv_pixels_add_end;
   logic               shift_add_end, busy, done;

   logic ack_auto, ack_force, sae_auto, sae_force, sae_en;
   int   ack_delay;
   int   n_tests, n_fail, done_cnt, cyc, min_cyc;
   ev_t  sb[$];

   assign rd_ack        = ack_auto | ack_force;
   assign shift_add_end = sae_auto | sae_force;

   shift_regs_ctrl dut (
      .clk                     (clk),
      .reset                   (reset),
      .start                   (start),
      .k                       (k),
      .s                       (s),
      .pad                     (pad),
      .in_w                    (in_w),
      .in_h                    (in_h),
      .rd_req                  (rd_req),
      .rd_ack                  (rd_ack),
      .row_start_idx           (row_start_idx),
      .row_end_idx             (row_end_idx),
      .row1_idx                (row1_idx),
      .row2_idx                (row2_idx),
      .row3_idx                (row3_idx),
      .row_valid               (row_valid),
      .west_pad                (west_pad),
      .slab_num                (slab_num),
      .east_pad                (east_pad),
      .reg_start_idx           (reg_start_idx),
      .reg_end_idx             (reg_end_idx),
      .conv_min_pixels_add_end (conv_min_pixels_add_end),
      .conv_pixels_add_end     (conv_pixels_add_end),
      .shift_add_end           (shift_add_end),
      .busy                    (busy),
      .done                    (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference walk of one tile: every fetch, pulse and done in order.
   task automatic build_expect(input int kk, input int ss, input int pp, input int ww, input int hh);
      int  oy, col, slab, prev, n, west, rs, re, r;
      ev_t e;
      oy = 0;
      prev = 0;
      forever begin
         col  = 0;
         slab = 0;
         do begin
            for (int c = 0; c < 2 && col < ww; c++) begin
               n    = (ww - col > 32) ? 32 : ww - col;
               west = (col == 0 && c == 0) ? pp : 0;
               rs   = (c == 0) ? slab + west + 1 : prev + 1;
               re   = rs + n - 1;
               e = '{default: 0};
               e.kind = EV_FETCH; e.rs = col; e.re = col + n - 1;
               e.gs = rs; e.ge = re; e.wp = west; e.slab = slab;
               e.r1 = oy * ss - pp;
               for (int j = 0; j < 3; j++) begin
                  r = oy * ss + j - pp;
                  e.rv[j] = (r >= 0 && r < hh);
               end
               sb.push_back(e);
               prev = re;
               col += n;
            end
            e = '{default: 0};
            e.kind = EV_MIN;
            sb.push_back(e);
            if (col == ww) begin
               e.kind = EV_PIX;
               e.wp   = pp;
               sb.push_back(e);
            end
            slab = kk - 1;
         end while (col < ww);
         oy++;
         if (oy * ss + kk - 2 * pp > hh) break;
      end
      e = '{default: 0};
      e.kind = EV_DONE;
      sb.push_back(e);
   endtask

   task automatic take(input int kind, output ev_t e);
      if (sb.size() == 0) begin
         e = '{default: 0};
         e.kind = EV_NONE;
      end else begin
         e = sb.pop_front();
      end
      chk("event_kind", kind, e.kind);
   endtask

   // Row-buffer responder: acknowledges ack_delay cycles after a request opens.
   initial begin
      int wcnt;
      ack_auto = 1'b0;
      wcnt = 0;
      forever begin
         @(posedge clk); #1;
         if (rd_req) begin
            if (wcnt >= ack_delay) begin
               ack_auto = 1'b1;
               wcnt = 0;
            end else begin
               ack_auto = 1'b0;
               wcnt++;
            end
         end else begin
            ack_auto = 1'b0;
            wcnt = 0;
         end
      end
   end

   // Datapath model: shift completes 3 cycles after the min-pixels pulse.
   initial begin
      int scnt;
      sae_auto = 1'b0;
      scnt = 0;
      forever begin
         @(posedge clk); #1;
         sae_auto = 1'b0;
         if (!sae_en) scnt = 0;
         else if (conv_min_pixels_add_end) scnt = 1;
         else if (scnt != 0) begin
            if (scnt == 3) begin
               sae_auto = 1'b1;
               scnt = 0;
            end else scnt++;
         end
      end
   end

   // Output monitor / scoreboard consumer.
   initial begin
      ev_t e;
      int  pk;
      cyc = 0;
      min_cyc = -10;
      done_cnt = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            if (rd_req) begin
               pk = (sb.size() == 0) ? EV_NONE : sb[0].kind;
               chk("fetch_kind", EV_FETCH, pk);
               chk("fetch_busy", busy, 1);
               chk("fetch_east", east_pad, 0);
               if (pk == EV_FETCH) begin
                  e = sb[0];
                  chk("row_start", row_start_idx, e.rs);
                  chk("row_end", row_end_idx, e.re);
                  chk("reg_start", reg_start_idx, e.gs);
                  chk("reg_end", reg_end_idx, e.ge);
                  chk("west_pad", west_pad, e.wp);
                  chk("slab_num", slab_num, e.slab);
                  chk("row1_idx", 32'(row1_idx), e.r1);
                  chk("row2_idx", 32'(row2_idx), e.r1 + 1);
                  chk("row3_idx", 32'(row3_idx), e.r1 + 2);
                  chk("row_valid", row_valid, e.rv);
               end
               if (!rd_ack) begin
                  chk("stall_min", conv_min_pixels_add_end, 0);
                  chk("stall_done", done, 0);
               end
               if (rd_ack && sb.size() > 0) void'(sb.pop_front());
            end
            if (conv_min_pixels_add_end) begin
               take(EV_MIN, e);
               min_cyc = cyc;
            end
            if (conv_pixels_add_end) begin
               take(EV_PIX, e);
               chk("pix_east", east_pad, e.wp);
               chk("pix_after_min", cyc - min_cyc, 1);
            end
            if (done) begin
               take(EV_DONE, e);
               done_cnt++;
            end
         end
      end
   end

   task automatic run_tile(input int kk, input int ss, input int pp, input int ww, input int hh);
      int d0;
      @(posedge clk); #1;
      k = 4'(kk); s = 4'(ss); pad = 4'(pp); in_w = 16'(ww); in_h = 16'(hh);
      start = 1'b1;
      build_expect(kk, ss, pp, ww, hh);
      @(posedge clk); #1;
      start = 1'b0;
      d0 = done_cnt;
      for (int i = 0; i < 5000 && done_cnt == d0; i++) @(negedge clk);
      chk("tile_done", done_cnt - d0, 1);
      @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      chk("idle_busy", busy, 0);
      sb.delete();
   endtask

   initial begin
      int d0;
      n_tests = 0; n_fail = 0;
      reset = 1'b0; start = 1'b0;
      k = '0; s = '0; pad = '0; in_w = '0; in_h = '0;
      ack_force = 1'b0; sae_force = 1'b0; sae_en = 1'b1; ack_delay = 0;

      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_rd_req", rd_req, 0);
      chk("rst_done", done, 0);
      chk("rst_min", conv_min_pixels_add_end, 0);
      chk("rst_pix", conv_pixels_add_end, 0);
      chk("rst_row1", 32'(row1_idx), 0);
      chk("rst_row3", 32'(row3_idx), 0);
      chk("rst_row_valid", row_valid, 0);
      chk("rst_reg_end", reg_end_idx, 0);
      chk("rst_slab", slab_num, 0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Single-chunk rows with padding on both sides.
      run_tile(3, 1, 1, 20, 3);

      // Two strips with slab overlap; stalled acks plus stray control inputs.
      ack_delay = 10;
      fork
         run_tile(3, 1, 0, 100, 3);
         begin
            for (int i = 0; i < 100 && !rd_req; i++) @(negedge clk);
            @(posedge clk); #1;
            start = 1'b1; k = 4'd1; in_w = 16'd5;
            @(posedge clk); #1;
            start = 1'b0; sae_force = 1'b1;
            @(posedge clk); #1;
            sae_force = 1'b0;
            for (int i = 0; i < 200 && !conv_min_pixels_add_end; i++) @(negedge clk);
            @(posedge clk); #1;
            ack_force = 1'b1;
            @(posedge clk); #1;
            ack_force = 1'b0;
         end
      join
      ack_delay = 0;

      // Asynchronous reset while the datapath is shifting.
      @(posedge clk); #1;
      k = 4'd3; s = 4'd1; pad = 4'd1; in_w = 16'd20; in_h = 16'd3;
      start = 1'b1;
      build_expect(3, 1, 1, 20, 3);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 200 && !conv_min_pixels_add_end; i++) @(negedge clk);
      @(negedge clk);
      chk("shift_east", east_pad, 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_east", east_pad, 0);
      chk("arst_pix", conv_pixels_add_end, 0);
      chk("arst_rd_req", rd_req, 0);
      chk("arst_row_valid", row_valid, 0);
      sb.delete();
      d0 = done_cnt;
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("arst_no_done", done_cnt - d0, 0);
      chk("arst_idle", busy, 0);

      // Restart after reset: stride 2, 1x1 kernel.
      run_tile(1, 2, 0, 8, 8);

      // Boundaries: 1-pixel tile, exactly two full chunks, partial last strip.
      run_tile(1, 1, 0, 1, 1);
      run_tile(3, 1, 1, 64, 2);
      ack_delay = int'($urandom_range(1, 3));
      run_tile(3, 2, 1, 70, 7);
      ack_delay = 0;

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_regs_ctrl.md
Name: shift_regs_ctrl

Overview:
- Sequencer for the 70-entry, 3-row shift-register datapath.
- Walks one feature-map tile row-by-row and strip-by-strip, fetching up to two 32-pixel chunks per strip from the row buffer, and drives the datapath's load window (reg_start/end, pads, slab count).
- Issues the min-pixels/all-pixels end pulses to the datapath and waits for its shift-done before the next strip or output row.

Parameters:
- shift_regs_num, 70, datapath register count
- pixels_in_row, 32, pixels per buffer read chunk
- chunks_per_strip, 2, maximum chunks loaded per strip

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches config, begins tile
- k  in  4  kernel size, 1 or 3
- s  in  4  stride, 1 or 2
- pad  in  4  padding, 0 or 1
- in_w  in  16  input width in pixels, 1..1024
- in_h  in  16  input height in rows, 1..1024
- rd_req  out  1  chunk read request
- rd_ack  in  1  chunk delivered to datapath this cycle
- row_start_idx  out  16  first column of requested chunk
- row_end_idx  out  16  last column of requested chunk
- row1_idx, row2_idx, row3_idx  out  16 each  input row indices (two's complement)
- row_valid  out  3  bit r=1 when row(r+1) is inside [0, in_h-1]
- west_pad, slab_num, east_pad  out  4 each  datapath fill controls
- reg_start_idx, reg_end_idx  out  16 each  datapath load window, 1-based
- conv_min_pixels_add_end  out  1  pulse: strip loaded, begin shifting
- conv_pixels_add_end  out  1  pulse: final strip of row loaded
- shift_add_end  in  1  datapath k-cycle shift complete
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse at tile end

Behaviour:
- Reset values: all outputs 0; state IDLE.
- States: IDLE -> FETCH -> LOAD -> (FETCH | MIN) -> SHIFT -> (FETCH | done).
- IDLE:
  - start latches k, s, pad, in_w, in_h.
  - Clears oy, col, chunk to 0; slab=0.
  - Goes to FETCH; busy=1 next cycle.
- Row indices: oy = output row; row(r)_idx = oy*s + r - 1 - pad for r=1..3. row_valid is computed combinationally from these.
- FETCH:
  - rd_req=1; n = min(32, in_w - col).
  - row_start_idx = col; row_end_idx = col + n - 1.
  - chunk 0: reg_start_idx = slab + west_pad + 1.
  - chunk 1: reg_start_idx = previous reg_end_idx + 1.
  - reg_end_idx = reg_start_idx + n - 1.
  - west_pad = pad only when col==0 and chunk==0, else 0.
  - Hold all outputs stable until rd_ack.
- LOAD (1 cycle after rd_ack):
  - col += n; chunk += 1.
  - If chunk < chunks_per_strip and col < in_w, go to FETCH; else go to MIN.
- MIN (1 cycle):
  - Pulse conv_min_pixels_add_end.
  - If col == in_w: east_pad = pad, and pulse conv_pixels_add_end in the next cycle (entering SHIFT).
  - Go to SHIFT.
- SHIFT:
  - Wait for shift_add_end. In the cycle it is seen, set slab = k - 1 and chunk = 0.
  - If col < in_w: go to FETCH.
  - Else: oy += 1, col = 0, slab = 0, east_pad = 0.
  - If oy*s + k - 2*pad > in_h (no further output row): pulse done, go to IDLE; else go to FETCH.
- Window limit: reg_end_idx + east_pad must be <= shift_regs_num. Guaranteed by slab<=2, pad<=1, 64 pixels, giving a maximum of 68.
- Simultaneous events:
  - rd_ack outside FETCH is ignored.
  - start while busy is ignored.
  - shift_add_end outside SHIFT is ignored.
- Reset mid-operation: immediate return to IDLE; all outputs 0; no done pulse.
- Arithmetic: 16-bit unsigned, except row indices, which are signed. n is never 0 because FETCH is entered only when col < in_w.

Decomposition:
- Shared package (shift_regs_pkg):
  - state enum
  - SHIFT_REGS_NUM=70 and PIXELS_IN_ROW=32 constants
  - k/s/pad legal-value constants
- One sub-module, shift_regs_win_calc: combinational n, reg_start/end and pad computation from col, chunk, slab and config.

Test Plan:
- k=3, s=1, pad=1, in_w=20, in_h=3, rd_ack immediate, shift_add_end 3 cycles after min pulse:
  - one FETCH per row: cols 0..19, reg_start=2, reg_end=21, west_pad=1, east_pad=1
  - min and all-pixels pulses on consecutive cycles
  - 3 rows, then done
  - row1_idx=-1 with row_valid=3'b110 on row 0
- k=3, s=1, pad=0, in_w=100:
  - strip 0: chunks 0..31 and 32..63 (reg 1..32, 33..64)
  - strip 1: slab=2, chunks 64..95 and 96..99 (reg_start 3, 35, reg_end 34, 38)
  - conv_pixels_add_end only after strip 1
- k=1, s=2, in_h=8: oy advances with row1_idx = 0, 2, 4, 6 (pad=0 so row1 = oy*s - 1 + 1), done after 4 rows; slab stays 0.
- rd_ack held low 10 cycles: rd_req and all index outputs stable throughout; no pulses.
- Reset (reset=0) asserted during SHIFT: outputs 0 asynchronously; a later start restarts at oy=0, col=0.
- start during busy and stray shift_add_end in FETCH: no state change, no extra pulses.
